// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select sequencer.
package mux_sel_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef logic [CH_W-1:0]   ch_t;
   typedef logic [NUM_CH-1:0] mask_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DWELL = 1'b1
   } state_e;

endpackage : mux_sel_pkg

// File: rtl/mux_sel_next.sv
// Channel navigation: finds the lowest enabled channel and the next enabled
// channel above the current one (circularly), and flags when that search
// wrapped back to an index at or below the current one.
module mux_sel_next
   import mux_sel_pkg::*;
(
   input  logic [CH_W-1:0]   ch_i,
   input  logic [NUM_CH-1:0] mask_i,
   output logic [CH_W-1:0]   next_ch_o,
   output logic              wrap_o,
   output logic [CH_W-1:0]   low_ch_o
);

   // Circular upward search from ch+1. Iterating from the farthest offset
   // down to the nearest lets the nearest enabled channel win without a break.
   // An empty mask leaves next = current and reports a wrap.
   always_comb begin
      // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
      next_ch_o = ch_i;
      for (int k = NUM_CH; k >= 1; k--) begin
         if (mask_i[CH_W'(ch_i + CH_W'(k))]) begin
            next_ch_o = CH_W'(ch_i + CH_W'(k));
         end
      end
      wrap_o = (next_ch_o <= ch_i);
   end

   // Lowest enabled channel; scanning downward so index 0 wins last.
   always_comb begin
      low_ch_o = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            low_ch_o = CH_W'(i);
         end
      end
   end

endmodule : mux_sel_next

// File: rtl/mux_sel_seq.sv
// Select sequencer driving the s1/s2 inputs of the 2-bit select mux.
// Steps through the enabled channels, holding each for a programmable dwell,
// with a strobe on the last cycle of every dwell. Single-pass or continuous.
module mux_sel_seq
   import mux_sel_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NUM_CH-1:0]  ch_mask,
   input  logic               continuous,
   output logic               s1,
   output logic               s2,
   output logic               busy,
   output logic               ch_valid,
   output logic               done
);

   localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   ch_t                ch_q, ch_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   mask_t              mask_q, mask_d;
   logic               cont_q, cont_d;
   logic               done_q, done_d;

   logic [DWELL_W-1:0] dwell_eff;
   mask_t              nav_mask;
   ch_t                next_ch;
   ch_t                low_ch;
   logic               wrap;

   // A zero dwell is held as a one-cycle dwell.
   assign dwell_eff = (dwell == '0) ? CNT_ONE : dwell;

   // While idle the navigator looks at the live mask (to find the first
   // channel); once scanning it only sees the latched configuration.
   assign nav_mask = (state_q == IDLE) ? ch_mask : mask_q;

   mux_sel_next u_next (
      .ch_i      (ch_q),
      .mask_i    (nav_mask),
      .next_ch_o (next_ch),
      .wrap_o    (wrap),
      .low_ch_o  (low_ch)
   );

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: start/latch in IDLE, count down and advance in DWELL.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if (ch_mask != '0) begin
                  dwell_d = dwell_eff;
                  mask_d  = ch_mask;
                  cont_d  = continuous;
                  ch_d    = low_ch;
                  cnt_d   = dwell_eff - CNT_ONE;
                  state_d = DWELL;
               end else begin
                  // Nothing to scan: report completion immediately.
                  done_d = 1'b1;
               end
            end
         end

         DWELL: begin
            if (stop) begin
               // Abort; selects hold where they are.
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               if (wrap && !cont_q) begin
                  // End of single pass; selects hold the last channel.
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  ch_d  = next_ch;
                  cnt_d = dwell_q - CNT_ONE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs, all derived directly from registers.
   always_comb begin
      s1       = ch_q[1];
      s2       = ch_q[0];
      busy     = (state_q == DWELL);
      ch_valid = (state_q == DWELL) && (cnt_q == '0);
      done     = done_q;
   end

endmodule : mux_sel_seq

// File: tb/tb_mux_sel_seq.sv
// Directed self-checking bench for mux_sel_seq.
module tb_mux_sel_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [7:0] dwell;
   logic [3:0] ch_mask;
   logic       continuous;
   logic       s1, s2, busy, ch_valid, done;

   int n_checks = 0;
   int n_errors = 0;

   mux_sel_seq #(.DWELL_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .dwell      (dwell),
      .ch_mask    (ch_mask),
      .continuous (continuous),
      .s1         (s1),
      .s2         (s2),
      .busy       (busy),
      .ch_valid   (ch_valid),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] sel, input logic b,
                             input logic v, input logic d);
      check({tag, ".sel"},      {30'd0, s1, s2}, {30'd0, sel});
      check({tag, ".busy"},     {31'd0, busy},   {31'd0, b});
      check({tag, ".ch_valid"}, {31'd0, ch_valid}, {31'd0, v});
      check({tag, ".done"},     {31'd0, done},   {31'd0, d});
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      dwell      = 8'd0;
      ch_mask    = 4'd0;
      continuous = 1'b0;
      #12;
      check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      check_outs("idle", 2'b00, 1'b0, 1'b0, 1'b0);

      // Single pass over all four channels, dwell 3.
      ch_mask = 4'b1111; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         check_outs($sformatf("pass.c%0d", cyc), 2'((cyc - 1) / 3), 1'b1,
                    (cyc % 3) == 0, 1'b0);
         tick();
      end
      check_outs("pass.end", 2'b11, 1'b0, 1'b0, 1'b1);
      tick();
      check_outs("pass.after", 2'b11, 1'b0, 1'b0, 1'b0);

      // Sparse mask, continuous, dwell 2: 1,1,3,3,1,1,...
      ch_mask = 4'b1010; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         check_outs($sformatf("cont.c%0d", cyc),
                    ((((cyc - 1) / 2) % 2) == 1) ? 2'd3 : 2'd1, 1'b1,
                    (cyc % 2) == 0, 1'b0);
         tick();
      end
      // Cycle 13: channel 1, first cycle of its dwell; abort here.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_outs("cont.stop", 2'd1, 1'b0, 1'b0, 1'b0);

      // Empty mask start: one done pulse, selects and busy untouched.
      ch_mask = 4'b0000; start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("empty", 2'd1, 1'b0, 1'b0, 1'b1);
      tick();
      check_outs("empty.after", 2'd1, 1'b0, 1'b0, 1'b0);

      // Dwell zero behaves as dwell one.
      ch_mask = 4'b0001; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("dz.hold", 2'd0, 1'b1, 1'b1, 1'b0);
      tick();
      check_outs("dz.end", 2'd0, 1'b0, 1'b0, 1'b1);

      // Stop on cycle 2 of a dwell-5 hold of channel 2.
      ch_mask = 4'b0100; dwell = 8'd5; continuous = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_outs("stop.c1", 2'd2, 1'b1, 1'b0, 1'b0);
      tick();
      stop = 1'b1;
      check_outs("stop.c2", 2'd2, 1'b1, 1'b0, 1'b0);
      tick();
      stop = 1'b0;
      check_outs("stop.after", 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("stop.quiet", 2'd2, 1'b0, 1'b0, 1'b0);

      // start and stop together while idle: stop wins.
      ch_mask = 4'b1111; dwell = 8'd2; start = 1'b1; stop = 1'b1;
      tick();
      check_outs("both.c1", 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      start = 1'b0; stop = 1'b0;
      check_outs("both.c2", 2'd2, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a scan of channel 2.
      ch_mask = 4'b0100; dwell = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_outs("rst.pre", 2'd2, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst.async", 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check_outs("rst.post", 2'd0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mux_sel_seq
